// File: rtl/hazard_unit.sv
// Pipeline hazard unit: forwarding selects, load-use/branch stalls, and a data-memory wait FSM.
// Optional stall performance counters are compiled in with `define HAZARD_PERF_EN.
//
//   state  | meaning
//   S_IDLE | no outstanding data-memory access
//   S_WAIT | access outstanding, wait counter running toward MEM_TIMEOUT
module hazard_unit #(
    parameter int REG_W       = 5,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] rsD,
    input  logic [REG_W-1:0] rtD,
    input  logic [REG_W-1:0] rsE,
    input  logic [REG_W-1:0] rtE,
    input  logic [REG_W-1:0] writeregE,
    input  logic             branchD,
    input  logic             memtoregE,
    input  logic             regwriteE,
    input  logic             memtoregM,
    input  logic             regwriteM,
    input  logic             memwriteM,
    input  logic             regwriteW,
    input  logic             dmem_ready,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             stallW,
    output logic             flushE,
    output logic             forwardAD,
    output logic             forwardBD,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic [REG_W-1:0] writeregM,
    output logic [REG_W-1:0] writeregW,
    output logic             mem_error
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]      lwstall_cnt,
    output logic [31:0]      brstall_cnt,
    output logic [31:0]      memstall_cnt
`endif
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT) + 1;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } mem_state_e;

    mem_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [REG_W-1:0] writeregM_q, writeregM_d;
    logic [REG_W-1:0] writeregW_q, writeregW_d;

    logic memreq, memstall, lwstall, brstall;

    // Register 0 is hard-wired, so it never participates in a hazard.
    function automatic logic reg_match(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
        return (a != '0) && (a == b);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src);
        if (reg_match(src, writeregM_q) && regwriteM)
            return 2'b10;
        else if (reg_match(src, writeregW_q) && regwriteW)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // Stalls are forced low while reset is held so the datapath sees a clean pipeline.
    always_comb begin
        memreq   = memtoregM || memwriteM;
        memstall = !reset && memreq && !dmem_ready;
        lwstall  = !reset && memtoregE &&
                   (reg_match(rsD, writeregE) || reg_match(rtD, writeregE));
        brstall  = !reset && branchD &&
                   ((regwriteE && (reg_match(rsD, writeregE) || reg_match(rtD, writeregE))) ||
                    (memtoregM && (reg_match(rsD, writeregM_q) || reg_match(rtD, writeregM_q))));
    end

    always_comb begin
        stallE    = memstall;
        stallM    = memstall;
        stallW    = memstall;
        stallF    = memstall || lwstall || brstall;
        stallD    = memstall || lwstall || brstall;
        flushE    = (lwstall || brstall) && !memstall;
        forwardAD = reg_match(rsD, writeregM_q) && regwriteM;
        forwardBD = reg_match(rtD, writeregM_q) && regwriteM;
        forwardAE = fwd_sel(rsE);
        forwardBE = fwd_sel(rtE);
        writeregM = writeregM_q;
        writeregW = writeregW_q;
        mem_error = err_q;
    end

    always_comb begin
        writeregM_d = writeregM_q;
        writeregW_d = writeregW_q;
        if (!memstall) begin
            writeregM_d = writeregE;
            writeregW_d = writeregM_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (memreq && !dmem_ready) begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (dmem_ready) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            writeregM_q <= '0;
            writeregW_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            writeregM_q <= writeregM_d;
            writeregW_q <= writeregW_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] lw_cnt_q, br_cnt_q, mem_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            lw_cnt_q  <= '0;
            br_cnt_q  <= '0;
            mem_cnt_q <= '0;
        end else begin
            if (lwstall && flushE)
                lw_cnt_q <= lw_cnt_q + 32'd1;
            if (brstall && flushE)
                br_cnt_q <= br_cnt_q + 32'd1;
            if (memstall)
                mem_cnt_q <= mem_cnt_q + 32'd1;
        end
    end

    assign lwstall_cnt  = lw_cnt_q;
    assign brstall_cnt  = br_cnt_q;
    assign memstall_cnt = mem_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized traffic against a reference model.
module tb_hazard_unit;

    localparam int REG_W = 5;
    localparam int TO    = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [REG_W-1:0] rsD, rtD, rsE, rtE, writeregE;
    logic             branchD, memtoregE, regwriteE, memtoregM, regwriteM, memwriteM, regwriteW;
    logic             dmem_ready;
    logic             stallF, stallD, stallE, stallM, stallW, flushE, forwardAD, forwardBD;
    logic [1:0]       forwardAE, forwardBE;
    logic [REG_W-1:0] writeregM, writeregW;
    logic             mem_error;

    int checks = 0;
    int errors = 0;

    hazard_unit #(.REG_W(REG_W), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE), .writeregE(writeregE),
        .branchD(branchD), .memtoregE(memtoregE), .regwriteE(regwriteE),
        .memtoregM(memtoregM), .regwriteM(regwriteM), .memwriteM(memwriteM),
        .regwriteW(regwriteW), .dmem_ready(dmem_ready),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
        .flushE(flushE), .forwardAD(forwardAD), .forwardBD(forwardBD),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .writeregM(writeregM), .writeregW(writeregW), .mem_error(mem_error)
    );

    always #5 clk = ~clk;

    // Reference model: pipeline of destinations and a run-length count of unanswered memory cycles.
    int m_wrM = 0, m_wrW = 0, m_run = 0;
    bit m_waiting = 0, m_err = 0;

    always @(posedge clk) begin
        bit frozen;
        if (reset) begin
            m_wrM = 0; m_wrW = 0; m_waiting = 0; m_run = 0; m_err = 0;
        end else begin
            frozen = (memtoregM || memwriteM) && !dmem_ready;
            if (!frozen) begin
                m_wrW = m_wrM;
                m_wrM = writeregE;
            end
            if (!m_waiting) begin
                if (frozen) begin m_waiting = 1; m_run = 1; end
            end else if (dmem_ready) begin
                m_waiting = 0;
            end else begin
                m_run++;
                if (m_run >= TO) m_err = 1;
            end
        end
    end

    function automatic bit same(input int a, input int b);
        return a != 0 && a == b;
    endfunction

    function automatic int m_fwd(input int src);
        if (same(src, m_wrM) && regwriteM) return 2;
        if (same(src, m_wrW) && regwriteW) return 1;
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        reset = 0; rsD = 0; rtD = 0; rsE = 0; rtE = 0; writeregE = 0;
        branchD = 0; memtoregE = 0; regwriteE = 0; memtoregM = 0; regwriteM = 0;
        memwriteM = 0; regwriteW = 0; dmem_ready = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1; memtoregM = 1; dmem_ready = 0;
        memtoregE = 1; writeregE = 8; rsD = 8;
        #2;
        checks++;
        if ({stallF, stallD, stallE, stallM, stallW, flushE} !== 6'b0) begin
            errors++; $display("FAIL reset_stalls: got %b expected 000000", {stallF, stallD, stallE, stallM, stallW, flushE});
        end
        tick();
        checks++;
        if (writeregM !== 0 || writeregW !== 0 || mem_error !== 0) begin
            errors++; $display("FAIL reset_state: got M=%0d W=%0d err=%0d expected 0 0 0", writeregM, writeregW, mem_error);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_load_use();
        clear_inputs();
        rtE = 8; writeregE = 8; memtoregE = 1; rsD = 8;
        #2;
        checks++;
        if ({stallF, stallD, flushE, stallE} !== 4'b1110) begin
            errors++; $display("FAIL load_use: got F/D/flushE/E=%b expected 1110", {stallF, stallD, flushE, stallE});
        end
        tick();
        memtoregE = 0;
        #2;
        checks++;
        if ({stallF, stallD, flushE} !== 3'b000) begin
            errors++; $display("FAIL load_use_after: got %b expected 000", {stallF, stallD, flushE});
        end
        rsD = 0; rtD = 8; memtoregE = 1;
        #1;
        checks++;
        if (flushE !== 1'b1) begin
            errors++; $display("FAIL load_use_rt: got %0d expected 1", flushE);
        end
        rtD = 0; writeregE = 0;
        #1;
        checks++;
        if (flushE !== 1'b0) begin
            errors++; $display("FAIL load_use_r0: got %0d expected 0", flushE);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_forwarding();
        clear_inputs();
        writeregE = 9;
        tick(); tick();
        regwriteM = 1; regwriteW = 1; rsE = 9; rtE = 9;
        #2;
        checks++;
        if (forwardAE !== 2'b10 || forwardBE !== 2'b10) begin
            errors++; $display("FAIL fwd_m_prio: got A=%b B=%b expected 10 10", forwardAE, forwardBE);
        end
        regwriteM = 0;
        #1;
        checks++;
        if (forwardAE !== 2'b01 || forwardBE !== 2'b01) begin
            errors++; $display("FAIL fwd_w: got A=%b B=%b expected 01 01", forwardAE, forwardBE);
        end
        writeregE = 0;
        tick(); tick();
        rsE = 0; rtE = 0; rsD = 0; regwriteM = 1;
        #2;
        checks++;
        if (forwardAE !== 2'b00 || forwardBE !== 2'b00 || forwardAD !== 1'b0) begin
            errors++; $display("FAIL fwd_r0: got A=%b B=%b AD=%0d expected 00 00 0", forwardAE, forwardBE, forwardAD);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_branch();
        clear_inputs();
        branchD = 1; rsD = 5; regwriteE = 1; writeregE = 5;
        #2;
        checks++;
        if (stallD !== 1'b1 || flushE !== 1'b1) begin
            errors++; $display("FAIL branch_e: got stallD=%0d flushE=%0d expected 1 1", stallD, flushE);
        end
        tick();
        regwriteE = 0; writeregE = 0; regwriteM = 1; memtoregM = 0;
        #2;
        checks++;
        if (stallD !== 1'b0 || flushE !== 1'b0 || forwardAD !== 1'b1) begin
            errors++; $display("FAIL branch_m: got stallD=%0d flushE=%0d AD=%0d expected 0 0 1", stallD, flushE, forwardAD);
        end
        memtoregM = 1; dmem_ready = 1;
        #1;
        checks++;
        if (stallD !== 1'b1 || flushE !== 1'b1) begin
            errors++; $display("FAIL branch_m_load: got stallD=%0d flushE=%0d expected 1 1", stallD, flushE);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_mem_wait();
        int stalled = 0;
        clear_inputs();
        writeregE = 3; tick();
        writeregE = 6; tick();
        writeregE = 12; memtoregM = 1; dmem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++;
            if ({stallF, stallD, stallE, stallM, stallW, flushE} !== 6'b111110) begin
                errors++; $display("FAIL mem_wait_stalls: cycle %0d got %b expected 111110", i, {stallF, stallD, stallE, stallM, stallW, flushE});
            end
            if (stallE) stalled++;
            tick();
            checks++;
            if (writeregM !== 6 || writeregW !== 3) begin
                errors++; $display("FAIL mem_wait_hold: got M=%0d W=%0d expected 6 3", writeregM, writeregW);
            end
        end
        dmem_ready = 1;
        #2;
        checks++;
        if ({stallF, stallD, stallE, stallM, stallW} !== 5'b0 || stalled != 3) begin
            errors++; $display("FAIL mem_wait_release: got %b after %0d stalled expected 00000 after 3", {stallF, stallD, stallE, stallM, stallW}, stalled);
        end
        tick();
        checks++;
        if (writeregM !== 12 || writeregW !== 6 || mem_error !== 0) begin
            errors++; $display("FAIL mem_wait_advance: got M=%0d W=%0d err=%0d expected 12 6 0", writeregM, writeregW, mem_error);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_overlap();
        clear_inputs();
        memtoregM = 1; dmem_ready = 0;
        memtoregE = 1; writeregE = 8; rsD = 8;
        for (int i = 0; i < 2; i++) begin
            #2;
            checks++;
            if (flushE !== 1'b0 || stallF !== 1'b1 || stallE !== 1'b1) begin
                errors++; $display("FAIL overlap_frozen: cycle %0d got flushE=%0d stallF=%0d stallE=%0d expected 0 1 1", i, flushE, stallF, stallE);
            end
            tick();
        end
        dmem_ready = 1;
        #2;
        checks++;
        if (flushE !== 1'b1 || stallF !== 1'b1 || stallE !== 1'b0) begin
            errors++; $display("FAIL overlap_release: got flushE=%0d stallF=%0d stallE=%0d expected 1 1 0", flushE, stallF, stallE);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_timeout();
        clear_inputs();
        reset = 1; tick(); reset = 0;
        memtoregM = 1; dmem_ready = 0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++;
            if (mem_error !== (i >= TO)) begin
                errors++; $display("FAIL timeout_err: after %0d cycles got %0d expected %0d", i, mem_error, (i >= TO));
            end
        end
        reset = 1;
        #2;
        checks++;
        if ({stallF, stallD, stallE, stallM, stallW, flushE} !== 6'b0) begin
            errors++; $display("FAIL timeout_reset_stalls: got %b expected 000000", {stallF, stallD, stallE, stallM, stallW, flushE});
        end
        tick();
        reset = 0; memtoregM = 0;
        #2;
        checks++;
        if (mem_error !== 1'b0 || stallF !== 1'b0 || stallE !== 1'b0) begin
            errors++; $display("FAIL timeout_cleared: got err=%0d stallF=%0d stallE=%0d expected 0 0 0", mem_error, stallF, stallE);
        end
        memtoregM = 1;
        tick(); tick(); tick();
        checks++;
        if (mem_error !== 1'b0) begin
            errors++; $display("FAIL timeout_restart: got %0d expected 0", mem_error);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_random();
        bit e_mem, e_lw, e_br;
        clear_inputs();
        reset = 1; tick();
        for (int n = 0; n < 2000; n++) begin
            reset      = ($urandom_range(0, 49) == 0);
            rsD        = REG_W'($urandom_range(0, 3));
            rtD        = REG_W'($urandom_range(0, 3));
            rsE        = REG_W'($urandom_range(0, 3));
            rtE        = REG_W'($urandom_range(0, 3));
            writeregE  = REG_W'($urandom_range(0, 3));
            branchD    = $urandom_range(0, 3) == 0;
            memtoregE  = $urandom_range(0, 2) == 0;
            regwriteE  = $urandom_range(0, 1) == 0;
            memtoregM  = $urandom_range(0, 2) == 0;
            memwriteM  = $urandom_range(0, 4) == 0;
            regwriteM  = $urandom_range(0, 1) == 0;
            regwriteW  = $urandom_range(0, 1) == 0;
            dmem_ready = $urandom_range(0, 3) != 0;
            #2;
            e_mem = !reset && (memtoregM || memwriteM) && !dmem_ready;
            e_lw  = !reset && memtoregE && (same(rsD, writeregE) || same(rtD, writeregE));
            e_br  = !reset && branchD &&
                    ((regwriteE && (same(rsD, writeregE) || same(rtD, writeregE))) ||
                     (memtoregM && (same(rsD, m_wrM) || same(rtD, m_wrM))));
            checks++;
            if ({stallE, stallM, stallW} !== {3{e_mem}}) begin
                errors++; $display("FAIL rnd_memstall: n=%0d got %b expected %b", n, {stallE, stallM, stallW}, {3{e_mem}});
            end
            checks++;
            if (stallF !== (e_mem || e_lw || e_br) || stallD !== (e_mem || e_lw || e_br)) begin
                errors++; $display("FAIL rnd_stallFD: n=%0d got %0d%0d expected %0d", n, stallF, stallD, (e_mem || e_lw || e_br));
            end
            checks++;
            if (flushE !== ((e_lw || e_br) && !e_mem)) begin
                errors++; $display("FAIL rnd_flushE: n=%0d got %0d expected %0d", n, flushE, ((e_lw || e_br) && !e_mem));
            end
            checks++;
            if (forwardAE !== 2'(m_fwd(rsE)) || forwardBE !== 2'(m_fwd(rtE))) begin
                errors++; $display("FAIL rnd_fwdE: n=%0d got %0d %0d expected %0d %0d", n, forwardAE, forwardBE, m_fwd(rsE), m_fwd(rtE));
            end
            checks++;
            if (forwardAD !== (same(rsD, m_wrM) && regwriteM) || forwardBD !== (same(rtD, m_wrM) && regwriteM)) begin
                errors++; $display("FAIL rnd_fwdD: n=%0d got %0d %0d expected %0d %0d", n, forwardAD, forwardBD, (same(rsD, m_wrM) && regwriteM), (same(rtD, m_wrM) && regwriteM));
            end
            checks++;
            if (writeregM !== REG_W'(m_wrM) || writeregW !== REG_W'(m_wrW) || mem_error !== m_err) begin
                errors++; $display("FAIL rnd_state: n=%0d got M=%0d W=%0d err=%0d expected %0d %0d %0d", n, writeregM, writeregW, mem_error, m_wrM, m_wrW, m_err);
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        tick(); tick();
        test_reset();
        test_load_use();
        test_forwarding();
        test_branch();
        test_mem_wait();
        test_overlap();
        test_timeout();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Consumer end of the pipeline control bundle produced by the instruction decoder.
- Takes the per-stage `memtoreg`/`regwrite`/`branch` flags together with register specifiers, and returns the flush, stall and forwarding controls to the datapath and decoder.
- Internally pipelines the destination register number from E to M to W.
- Runs a data-memory wait FSM that freezes the whole pipeline while a load or store is outstanding.

Parameters:
- `REG_W`, 5, register-specifier width.
- `MEM_TIMEOUT`, 64, maximum wait cycles before `mem_error` is raised; minimum 2.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `rsD`, `rtD`  in  `REG_W`  source specifiers in Decode.
- `rsE`, `rtE`  in  `REG_W`  source specifiers in Execute.
- `writeregE`  in  `REG_W`  destination selected in Execute.
- `branchD`  in  1  branch in Decode.
- `memtoregE`, `regwriteE`  in  1  Execute-stage control.
- `memtoregM`, `regwriteM`, `memwriteM`  in  1  Memory-stage control.
- `regwriteW`  in  1  Writeback-stage control.
- `dmem_ready`  in  1  data memory has completed the current access.
- `stallF`, `stallD`  out  1  hold PC and the IF/ID register.
- `stallE`, `stallM`, `stallW`  out  1  hold the ID/EX, EX/MEM and MEM/WB registers (memory wait only).
- `flushE`  out  1  bubble into ID/EX.
- `forwardAD`, `forwardBD`  out  1  Decode comparator bypass from M.
- `forwardAE`, `forwardBE`  out  2  ALU operand select: 00 = regfile, 01 = W result, 10 = M ALU result.
- `writeregM`, `writeregW`  out  `REG_W`  internally pipelined destinations.
- `mem_error`  out  1  sticky timeout flag.

Behaviour:
- Reset (sync, active-high): `writeregM`/`writeregW` = 0, FSM = IDLE, wait counter = 0, `mem_error` = 0.
  - All outputs combinationally derived from this state, so all stalls/flush are 0 while `reset` is high.
- Destination pipeline:
  - Each cycle where `stallM` = 0: `writeregM` <= `writeregE`.
  - Each cycle where `stallW` = 0: `writeregW` <= `writeregM`.
  - Held during a memory stall.
- Register 0 never matches in any comparison below.
- Execute forwarding, A operand (B identical using `rtE`/`forwardBE`):
  - 10 if `rsE` == `writeregM` and `regwriteM`;
  - else 01 if `rsE` == `writeregW` and `regwriteW`;
  - else 00.
  - M has priority over W.
- Decode forwarding: `forwardAD` = (`rsD` == `writeregM`) and `regwriteM`; `forwardBD` likewise with `rtD`.
- `lwstall` = `memtoregE` and (`rsD` == `writeregE` or `rtD` == `writeregE`).
- `brstall` = `branchD` and either:
  - `regwriteE` and `writeregE` matches `rsD`/`rtD`; or
  - `memtoregM` and `writeregM` matches `rsD`/`rtD`.
- `memreq` = `memtoregM` or `memwriteM`.
- Memory FSM:
  - IDLE: if `memreq` and not `dmem_ready` -> WAIT, counter <= 1.
  - WAIT: if `dmem_ready` -> IDLE, counter <= 0.
  - WAIT: else if counter == `MEM_TIMEOUT`-1 -> `mem_error` <= 1, remain in WAIT.
  - WAIT: else counter++ (saturates).
  - `memstall` = `memreq` and not `dmem_ready`, in either state, combinationally.
  - Access completing with `dmem_ready` = 1 in the request cycle costs zero stall cycles.
- Outputs:
  - `stallE`/`stallM`/`stallW` = `memstall`.
  - `stallF` = `stallD` = `memstall` or `lwstall` or `brstall`.
  - `flushE` = (`lwstall` or `brstall`) and not `memstall`. A bubble is never injected while frozen; the hazard re-evaluates after release.
- Simultaneous load-use and memory wait: memory wait dominates; the load-use stall is then applied on the first unfrozen cycle.
- `mem_error` clears only on reset.
- Reset mid-WAIT returns to IDLE in the next cycle regardless of `dmem_ready`.

Optional Feature:
- Macro `HAZARD_PERF_EN`.
- When defined, adds three 32-bit outputs, `lwstall_cnt`, `brstall_cnt` and `memstall_cnt`:
  - Each increments on every cycle its condition gates the pipeline (`lwstall`/`brstall` counted only when `flushE` = 1).
  - Wrap at 2^32.
  - Cleared on reset.
- When undefined, these ports and registers are absent; all other behaviour is unchanged.

Test Plan:
- Load-use: `rtE`=8, `memtoregE`=1, `rsD`=8, `dmem_ready`=1 -> `stallF`=`stallD`=`flushE`=1 for one cycle, `stallE`=0.
- Forwarding priority:
  - `writeregM`=`writeregW`=9, both regwrites=1, `rsE`=9 -> `forwardAE`=10.
  - Drop `regwriteM` -> 01.
  - `rsE`=0 with `writeregM`=0 -> 00.
- Branch hazard: `branchD`=1, `rsD`=5, `regwriteE`=1, `writeregE`=5 -> `stallD`=1, `flushE`=1; next cycle, M-stage match with `regwriteM`=1 and `memtoregM`=0 -> no stall, `forwardAD`=1.
- Memory wait: `memtoregM`=1, `dmem_ready` low for 3 cycles -> all five stalls high exactly 3 cycles, `flushE`=0 throughout, `writeregM`/`writeregW` unchanged, release on ready.
- Timeout/reset: `MEM_TIMEOUT`=4, ready never asserted -> `mem_error`=1 after 4 stalled cycles; assert `reset` one cycle -> FSM IDLE, `mem_error`=0, all stalls 0.
- Overlap: load-use present while memory wait lasts 2 cycles -> `flushE`=0 during the wait, `flushE`=1 on the first unfrozen cycle.
